// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32 execute-stage ALU blocks.
//   XLEN         : datapath width in bits
//   div_state_t  : controller states of the sequential divider
//   F3_*         : funct3 encodings of the M-extension divide/remainder ops
//   is_div_funct3 / funct3_is_signed : decoder helpers that drive is_signed
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // True for any of the four divide/remainder operations.
  function automatic logic is_div_funct3(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  // DIV and REM treat operands as two's complement.
  function automatic logic funct3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/busy/done handshake between the execute stage and the divider.
//   i_start      : request a division (sampled only while not busy)
//   i_is_signed  : 1 = DIV/REM, 0 = DIVU/REMU
//   i_a / i_b    : dividend / divisor
//   o_busy       : operation in progress
//   o_done       : one-cycle completion pulse
//   o_quotient / o_remainder : results, held until the next accepted start
// Modports: master (requester) and slave (divider).
// -----------------------------------------------------------------------------
interface seq_divider_if
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
);

  logic             i_start;
  logic             i_is_signed;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;

  modport master (
    output i_start, i_is_signed, i_a, i_b,
    input  o_busy, o_done, o_quotient, o_remainder
  );

  modport slave (
    input  i_start, i_is_signed, i_a, i_b,
    output o_busy, o_done, o_quotient, o_remainder
  );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   i_rem      : partial remainder (always < i_divisor on entry)
//   i_dvd_msb  : next dividend bit shifted into the remainder
//   i_divisor  : unsigned divisor magnitude
//   o_rem      : next partial remainder
//   o_q_bit    : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  assign w_shifted = {i_rem, i_dvd_msb};
  assign w_trial   = w_shifted - {1'b0, i_divisor};

  // Because i_rem < i_divisor, the trial lies in [-divisor, divisor-1], so the
  // top bit of the WIDTH+1 result is a reliable sign bit.
  assign o_q_bit = ~w_trial[WIDTH];
  assign o_rem   = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : seq_divider_if slave (start/operands in, busy/done/results out)
// Latency: 34 cycles normally, 2 cycles for divide-by-zero / signed overflow.
// -----------------------------------------------------------------------------
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_dvd;      // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_next_rem;
  logic             w_q_bit;

  assign w_a_neg    = bus.i_is_signed & bus.i_a[WIDTH-1];
  assign w_b_neg    = bus.i_is_signed & bus.i_b[WIDTH-1];
  // -MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude.
  assign w_a_mag    = w_a_neg ? -bus.i_a : bus.i_a;
  assign w_b_mag    = w_b_neg ? -bus.i_b : bus.i_b;
  assign w_div_zero = (bus.i_b == '0);
  assign w_overflow = bus.i_is_signed && (bus.i_a == MIN_NEG) && (bus.i_b == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_next_rem),
    .o_q_bit   (w_q_bit)
  );

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block sees the pre-edge value of every other, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_busy <= 1'b1;
            r_count <= '0;
            r_dvs   <= w_b_mag;
            if (w_div_zero || w_overflow) begin
              // Special results are staged in the datapath and pass through
              // FIX with no sign correction, giving the 2-cycle latency.
              r_dvd   <= w_div_zero ? '1 : MIN_NEG;
              r_rem   <= w_div_zero ? bus.i_a : '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= FIX;
            end else begin
              r_dvd   <= w_a_mag;
              r_rem   <= '0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_state <= RUN;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_rem   <= w_next_rem;
          r_dvd   <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_quotient  <= r_neg_q ? -r_dvd : r_dvd;
          r_remainder <= r_neg_r ? -r_rem : r_rem;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_quotient  = r_quotient;
  assign bus.o_remainder = r_remainder;

endmodule
